// File: rtl/data_memory_bytelane.sv
// Byte-addressed RV32I data memory with byte lanes, registered load data, fault flags
// and a post-reset clear sequencer.
module data_memory_bytelane #(
   parameter int unsigned NUM_WORDS      = 256,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        MemRead,
   input  logic        MemWr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        ready,
   output logic        misaligned,
   output logic        out_of_range
);

   localparam int unsigned AW = $clog2(NUM_WORDS);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   state_e        state_q;
   logic [AW-1:0] cnt_q;
   logic          ready_q;
   logic [31:0]   read_data_q;
   logic          read_valid_q;
   logic          misaligned_q;
   logic          out_of_range_q;
   logic [31:0]   mem_q [NUM_WORDS];

   logic          req;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          mis_c;
   logic          oor_c;
   logic          fault;
   logic          we;
   logic [3:0]    be;
   logic [31:0]   wrep;
   logic [31:0]   old_word;
   logic [31:0]   merged;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   read_data_d;

   assign req      = (MemRead | MemWr) & ready_q;
   assign idx      = addr[AW+1:2];
   assign off      = addr[1:0];
   assign oor_c    = |addr[31:AW+2];
   assign fault    = mis_c | oor_c;
   assign we       = req & MemWr & ~fault;
   assign old_word = mem_q[idx];

   // Lane enables and replicated store data per access size.
   always_comb begin
      mis_c = 1'b0;
      be    = 4'b0000;
      wrep  = write_data;
      case (funct3)
         3'b000, 3'b100: begin
            be   = 4'b0001 << off;
            wrep = {4{write_data[7:0]}};
         end
         3'b001, 3'b101: begin
            mis_c = off[0];
            be    = off[1] ? 4'b1100 : 4'b0011;
            wrep  = {2{write_data[15:0]}};
         end
         3'b010: begin
            mis_c = (off != 2'b00);
            be    = 4'b1111;
         end
         default: mis_c = 1'b1;
      endcase
   end

   always_comb begin
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) merged[8*b +: 8] = wrep[8*b +: 8];
      end
   end

   always_comb begin
      byte_sel = merged[7:0];
      case (off)
         2'b01:   byte_sel = merged[15:8];
         2'b10:   byte_sel = merged[23:16];
         2'b11:   byte_sel = merged[31:24];
         default: byte_sel = merged[7:0];
      endcase
      half_sel = off[1] ? merged[31:16] : merged[15:0];
   end

   // A combined read+write returns the whole merged word.
   always_comb begin
      read_data_d = '0;
      if (MemWr) begin
         read_data_d = merged;
      end else begin
         case (funct3)
            3'b000:  read_data_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  read_data_d = {24'b0, byte_sel};
            3'b001:  read_data_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  read_data_d = {16'b0, half_sel};
            3'b010:  read_data_d = merged;
            default: read_data_d = '0;
         endcase
      end
      if (fault) read_data_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q        <= CLEAR_ON_RESET ? StClear : StIdle;
         cnt_q          <= '0;
         ready_q        <= 1'b0;
         read_data_q    <= '0;
         read_valid_q   <= 1'b0;
         misaligned_q   <= 1'b0;
         out_of_range_q <= 1'b0;
      end else begin
         read_valid_q   <= req & MemRead;
         misaligned_q   <= req & mis_c;
         out_of_range_q <= req & oor_c;
         if (req && MemRead) read_data_q <= read_data_d;
         case (state_q)
            StClear: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(NUM_WORDS - 1)) begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
               end
            end
            StIdle:  ready_q <= 1'b1;
            default: state_q <= StClear;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         if (state_q == StClear) mem_q[cnt_q] <= '0;
         else if (we)            mem_q[idx]   <= merged;
      end
   end

   assign read_data    = read_data_q;
   assign read_valid   = read_valid_q;
   assign ready        = ready_q;
   assign misaligned   = misaligned_q;
   assign out_of_range = out_of_range_q;

endmodule
